// File: rtl/adc_interleave_seq.sv
// Interleaved-ADC channel sequencer: picks one of NUM_CH converter words per accepted
// strobe (manual select or round-robin over an enable mask) into a single output register.
module adc_interleave_seq #(
   parameter int NUM_CH = 16,
   parameter int DATA_W = 32,
   localparam int SEL_W = $clog2(NUM_CH)
) (
   input  logic                       clk,
   input  logic                       GlobalReset_n,
   input  logic [NUM_CH*DATA_W-1:0]   x_adc_bus,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       mode,
   input  logic [SEL_W-1:0]           x_adc_select,
   input  logic [NUM_CH-1:0]          ch_enable,
   input  logic                       restart,
   output logic [DATA_W-1:0]          x_adc,
   output logic [SEL_W-1:0]           x_adc_ch,
   output logic                       x_adc_valid,
   input  logic                       x_adc_ready,
   output logic                       seq_wrap,
   output logic                       sel_err
);

   logic [SEL_W-1:0]  seq_ptr;
   logic [SEL_W-1:0]  auto_sel;
   logic              auto_hit;
   logic [SEL_W-1:0]  nxt_ptr;
   logic              nxt_hit;
   logic [SEL_W-1:0]  low_ptr;
   logic [SEL_W-1:0]  man_sel;
   logic              man_in_range;
   logic              man_en;
   logic [SEL_W-1:0]  sel;
   logic [DATA_W-1:0] sel_data;
   logic              sel_err_d;
   logic              seq_wrap_d;
   logic              mask_empty;
   logic              accept;

   function automatic logic [SEL_W-1:0] wrap_idx(input int v);
      return SEL_W'(v % NUM_CH);
   endfunction

   assign mask_empty = (ch_enable == '0);
   assign in_ready   = (!x_adc_valid || x_adc_ready) && !(mode && mask_empty);
   assign accept     = in_valid && in_ready;

   // First enabled channel at or after seq_ptr, circular.
   always_comb begin
      auto_sel = '0;
      auto_hit = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!auto_hit && ch_enable[wrap_idx(int'(seq_ptr) + i)]) begin
            auto_sel = wrap_idx(int'(seq_ptr) + i);
            auto_hit = 1'b1;
         end
      end
   end

   // First enabled channel strictly after auto_sel; offset NUM_CH lands back on auto_sel.
   always_comb begin
      nxt_ptr = auto_sel;
      nxt_hit = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
         if (!nxt_hit && ch_enable[wrap_idx(int'(auto_sel) + i)]) begin
            nxt_ptr = wrap_idx(int'(auto_sel) + i);
            nxt_hit = 1'b1;
         end
      end
   end

   always_comb begin
      low_ptr = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (ch_enable[k]) low_ptr = SEL_W'(k);
      end
   end

   // Range check by matching against real channels, so non-power-of-two NUM_CH works.
   always_comb begin
      man_in_range = 1'b0;
      man_en       = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (x_adc_select == SEL_W'(k)) begin
            man_in_range = 1'b1;
            man_en       = ch_enable[k];
         end
      end
      man_sel = man_in_range ? x_adc_select : '0;
   end

   always_comb begin
      sel        = mode ? auto_sel : man_sel;
      sel_err_d  = mode ? 1'b0 : (!man_in_range || !man_en);
      seq_wrap_d = mode ? (nxt_ptr <= auto_sel) : 1'b0;
      sel_data   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (sel == SEL_W'(k)) sel_data = x_adc_bus[k*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge GlobalReset_n) begin
      if (!GlobalReset_n) begin
         x_adc       <= '0;
         x_adc_ch    <= '0;
         x_adc_valid <= 1'b0;
         seq_wrap    <= 1'b0;
         sel_err     <= 1'b0;
         seq_ptr     <= '0;
      end else begin
         if (accept) begin
            x_adc       <= sel_data;
            x_adc_ch    <= sel;
            sel_err     <= sel_err_d;
            seq_wrap    <= seq_wrap_d;
            x_adc_valid <= 1'b1;
         end else if (x_adc_ready) begin
            x_adc_valid <= 1'b0;
         end
         // restart overrides the pointer advance of a coincident auto accept
         if (restart) begin
            seq_ptr <= low_ptr;
         end else if (accept && mode) begin
            seq_ptr <= nxt_ptr;
         end
      end
   end

endmodule

// File: doc/adc_interleave_seq.md
# adc_interleave_seq

Parametrised interleaved-ADC channel sequencer and mux with a registered output stage. It takes NUM_CH parallel converter words per sample strobe and forwards one selected channel per accepted strobe, tagged with its channel index, over a valid/ready handshake. Channel selection is either manual (external select) or automatic (internal round-robin over an enable mask). It sits between the interleaved ADC front-end bank and the downstream per-channel calibration/DSP path.

## Interface
- NUM_CH, 16, number of interleaved channels (2..64); SEL_W = $clog2(NUM_CH) is derived, not overridable
- DATA_W, 32, width of one channel word
- clk  input  1  rising-edge clock
- GlobalReset_n  input  1  asynchronous, active-low reset
- x_adc_bus  input  NUM_CH*DATA_W  channel words; channel k occupies bits [k*DATA_W +: DATA_W]
- in_valid  input  1  x_adc_bus holds a new sample set
- in_ready  output  1  block can accept (combinational)
- mode  input  1  0 = manual, 1 = auto round-robin
- x_adc_select  input  SEL_W  channel index in manual mode
- ch_enable  input  NUM_CH  auto-mode channel mask; also flags errors in manual mode
- restart  input  1  synchronous pulse that rewinds the auto sequence
- x_adc  output  DATA_W  selected channel word
- x_adc_ch  output  SEL_W  channel index of x_adc
- x_adc_valid  output  1  output beat valid
- x_adc_ready  input  1  downstream accepts beat
- seq_wrap  output  1  beat is the last enabled channel of an auto sequence
- sel_err  output  1  beat came from an out-of-range or disabled channel

## Operation
- Accept = in_valid && in_ready. in_ready = (!x_adc_valid || x_adc_ready) && !(mode && ch_enable == 0).
- Selected channel on accept:
  - Manual: sel = x_adc_select. If x_adc_select >= NUM_CH, forward channel 0 data with x_adc_ch = 0 and sel_err = 1. If the channel is in range but ch_enable[sel] = 0, forward it anyway with sel_err = 1.
  - Auto: sel = first enabled channel at or after seq_ptr, searching circularly. sel_err = 0.
- On accept, register x_adc, x_adc_ch, sel_err and seq_wrap, and set x_adc_valid = 1.
- Without accept: if x_adc_ready, clear x_adc_valid. Otherwise hold all outputs stable.
- seq_ptr (internal, SEL_W bits):
  - Auto accept: seq_ptr <= first enabled channel strictly after sel, searching circularly.
  - seq_wrap = 1 when that next index <= sel. With a single enabled channel, every beat wraps.
  - Manual mode: seq_ptr holds and seq_wrap = 0.
- restart: seq_ptr <= lowest enabled channel, or 0 if the mask is empty. If restart coincides with an auto accept, the accept uses the old seq_ptr and restart wins for the next value.
- ch_enable changes take effect at the next accept. Resolving at the search step means a newly disabled seq_ptr target is skipped.
- Mode switches take effect at the next accept. No flush is needed.

## Timing
- Reset values (asynchronous): x_adc = 0, x_adc_ch = 0, x_adc_valid = 0, seq_wrap = 0, sel_err = 0, seq_ptr = 0.
- After reset, in_ready = 1 unless mode = 1 and the mask is empty.
- Latency: accept in cycle N gives x_adc_valid in cycle N+1.
- Throughput: 1 beat/cycle while x_adc_ready = 1. A new accept in the same cycle as an output handshake is allowed.
- Backpressure: x_adc_valid && !x_adc_ready gives in_ready = 0. x_adc, x_adc_ch, seq_wrap and sel_err stay unchanged until the handshake completes.
- Reset asserted mid-stream: outputs clear immediately, the pending beat is dropped and seq_ptr returns to 0.
- Search logic is combinational over NUM_CH. The single output register is the only pipeline stage.

## Test plan
- Reset, then auto mode, ch_enable = 16'hFFFF, in_valid held high, x_adc_ready = 1, channel k word = 32'hA000_0000 + k -> x_adc_ch counts 0..15..0, x_adc = 32'hA000_000k, seq_wrap = 1 only on ch 15, one beat per cycle with 1-cycle latency.
- Auto with ch_enable = 16'h0025 -> channel order 0, 2, 5, 0, …, seq_wrap on ch 5. Then set the mask to 16'h0004 -> every beat is ch 2 with seq_wrap = 1. Then set the mask to 0 -> in_ready = 0 and no beats.
- Manual, NUM_CH = 12, x_adc_select = 4'd13 -> x_adc = channel 0 word, x_adc_ch = 0, sel_err = 1. x_adc_select = 3 with ch_enable[3] = 0 -> channel 3 word, sel_err = 1.
- Auto, hold x_adc_ready = 0 for 5 cycles mid-sequence -> in_ready = 0 and outputs frozen. On release, the sequence resumes at the next enabled channel with no skip or repeat.
- restart pulsed on the same cycle as an auto accept of ch 7 (mask 16'hFFF0) -> this beat is ch 7 and the next beat is ch 4.
- GlobalReset_n pulled low asynchronously mid-cycle while x_adc_valid = 1 -> all outputs are 0 before the next clk edge. After release, auto resumes from ch 0 (or the first enabled channel).
